bomb_sequencer: RTL and testbench

BOMB_SEQUENCER -- requirements
Module: bomb_sequencer

---
 rtl/bomb_sequencer.sv | 140 ++++++++++++++
 tb/tb_bomb_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bomb_sequencer.sv
// bomb_sequencer: single-bomb fuse/blast FSM driving the bomb and blast-cross pixel layers
module bomb_sequencer #(
  parameter int FUSE_CYCLES  = 200_000_000,
  parameter int BLAST_CYCLES = 50_000_000,
  parameter int RANGE        = 2,
  parameter int TILE_SHIFT   = 5,
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        place,
  input  logic        game_over,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic        bomb_on,
  output logic        explosion_on,
  output logic [11:0] bomb_rgb,
  output logic [11:0] explosion_rgb,
  output logic        busy,
  output logic        blast_start,
  output logic [4:0]  bomb_tx,
  output logic [4:0]  bomb_ty,
  output logic        player_hit
);
  typedef enum logic [1:0] {IDLE, FUSE, BLAST} state_t;
  localparam logic [27:0] FUSE_LAST  = 28'(FUSE_CYCLES - 1);
  localparam logic [27:0] BLAST_LAST = 28'(BLAST_CYCLES - 1);
  state_t      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [4:0]  tx_q, tx_d, ty_q, ty_d;
  logic        place_q, armed_q, armed_d, hit_q, hit_d;
  logic        blast_start_q, blast_start_d, player_hit_q, player_hit_d;
  logic [10:0] cx, cy, px, py;
  logic        place_edge, pix_cross, body_cross;

  // Signed arithmetic keeps tiles near the edge from wrapping to the far side.
  function automatic logic in_cross(input logic [10:0] x, input logic [10:0] y,
                                    input logic [4:0] tx, input logic [4:0] ty);
    int dx, dy;
    dx = int'(x) - int'(tx);
    dy = int'(y) - int'(ty);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H) &&
           (((dy == 0) && (dx >= -RANGE) && (dx <= RANGE)) ||
            ((dx == 0) && (dy >= -RANGE) && (dy <= RANGE)));
  endfunction

  always_comb begin
    cx = ({1'b0, b_x} + 11'd16) >> TILE_SHIFT;
    cy = ({1'b0, b_y} + 11'd16) >> TILE_SHIFT;
    px = {1'b0, v_x} >> TILE_SHIFT;
    py = {1'b0, v_y} >> TILE_SHIFT;
    pix_cross = in_cross(px, py, tx_q, ty_q);
    body_cross = in_cross(cx, cy, tx_q, ty_q);
    // armed_q stays low after reset until place is seen low, so a held button never fires.
    armed_d = armed_q || !place;
    place_edge = place && !place_q && armed_q && !game_over;
    state_d = state_q;
    cnt_d = cnt_q + 28'd1;
    tx_d = tx_q;
    ty_d = ty_q;
    hit_d = hit_q;
    blast_start_d = 1'b0;
    player_hit_d = 1'b0;
    if (game_over) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (place_edge) begin
            state_d = FUSE;
            tx_d = cx[4:0];
            ty_d = cy[4:0];
          end
        end
        FUSE: begin
          if (cnt_q == FUSE_LAST) begin
            state_d = BLAST;
            cnt_d = '0;
            blast_start_d = 1'b1;
            hit_d = 1'b0;
          end
        end
        BLAST: begin
          if (!hit_q && body_cross) begin
            player_hit_d = 1'b1;
            hit_d = 1'b1;
          end
          if (cnt_q == BLAST_LAST) begin
            state_d = IDLE;
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      place_q <= 1'b0;
      armed_q <= 1'b0;
      hit_q <= 1'b0;
      blast_start_q <= 1'b0;
      player_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      place_q <= place;
      armed_q <= armed_d;
      hit_q <= hit_d;
      blast_start_q <= blast_start_d;
      player_hit_q <= player_hit_d;
    end
  end

  assign bomb_on = (state_q == FUSE) && (px == {6'd0, tx_q}) && (py == {6'd0, ty_q}) &&
                   (int'(px) < GRID_W) && (int'(py) < GRID_H);
  assign explosion_on = (state_q == BLAST) && pix_cross;
  assign bomb_rgb = 12'h222;
  assign explosion_rgb = 12'hF80;
  assign busy = state_q != IDLE;
  assign blast_start = blast_start_q;
  assign player_hit = player_hit_q;
  assign bomb_tx = tx_q;
  assign bomb_ty = ty_q;
endmodule

// File: tb/tb_bomb_sequencer.sv
// tb_bomb_sequencer: directed checks of placement, fuse/blast timing, blast cross, hits, abort and reset
module tb_bomb_sequencer;
  logic        sys_clk, Reset, place, game_over;
  logic [9:0]  b_x, b_y, v_x, v_y;
  logic        bomb_on, explosion_on, busy, blast_start, player_hit;
  logic [11:0] bomb_rgb, explosion_rgb;
  logic [4:0]  bomb_tx, bomb_ty;
  int checks = 0, failures = 0;
  int bs_cnt = 0, ph_cnt = 0;

  bomb_sequencer #(.FUSE_CYCLES(10), .BLAST_CYCLES(5), .RANGE(2)) dut (
    .sys_clk(sys_clk), .Reset(Reset), .place(place), .game_over(game_over),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .bomb_on(bomb_on), .explosion_on(explosion_on),
    .bomb_rgb(bomb_rgb), .explosion_rgb(explosion_rgb),
    .busy(busy), .blast_start(blast_start),
    .bomb_tx(bomb_tx), .bomb_ty(bomb_ty), .player_hit(player_hit)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (blast_start) bs_cnt++;
    if (player_hit) ph_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_blast(output int cyc);
    cyc = 0;
    while (!blast_start && cyc < 40) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      step(1);
      cyc++;
    end
  endtask

  int cyc, bs0, ph0, busy_seen;
  int sx[12] = '{0, 1, 2, 3, 0, 0, 0, 1, 19, 0, 19, 25};
  int sy[12] = '{0, 0, 0, 0, 1, 2, 3, 1, 0, 14, 14, 0};
  logic se[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    Reset = 1'b1; place = 1'b0; game_over = 1'b0;
    b_x = 10'd100; b_y = 10'd100; v_x = 10'd100; v_y = 10'd100;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_blast_start", blast_start, 0);
    check("rst_hit", player_hit, 0);
    check("rst_tx", bomb_tx, 0);
    check("rst_bomb_on", bomb_on, 0);
    check("rgb", {8'd0, bomb_rgb, explosion_rgb}, 32'h222F80);
    Reset = 1'b0;
    step(2);
    bs0 = bs_cnt; ph0 = ph_cnt;
    place = 1'b1;
    step(1);
    check("place_busy", busy, 1);
    check("place_tx", bomb_tx, 3);
    check("place_ty", bomb_ty, 3);
    check("bomb_on_tile", bomb_on, 1);
    check("fuse_no_expl", explosion_on, 0);
    v_x = 10'd140;
    #1;
    check("bomb_on_other", bomb_on, 0);
    b_x = 10'd132;
    wait_blast(cyc);
    check("fuse_len", cyc, 10);
    wait_idle(cyc);
    check("blast_len", cyc, 5);
    check("hit_adjacent", ph_cnt - ph0, 1);
    step(40);
    check("held_one_blast", bs_cnt - bs0, 1);
    check("held_idle", busy, 0);
    place = 1'b0;
    step(1);
    bs0 = bs_cnt; ph0 = ph_cnt;
    b_x = 10'd100; b_y = 10'd100;
    place = 1'b1;
    step(1);
    b_x = 10'd132; b_y = 10'd132;
    place = 1'b0;
    step(1);
    place = 1'b1;
    step(1);
    wait_blast(cyc);
    check("second_edge_ignored", cyc, 8);
    wait_idle(cyc);
    step(3);
    check("no_queued_bomb", busy, 0);
    check("no_hit_diagonal", ph_cnt - ph0, 0);
    check("one_blast_start", bs_cnt - bs0, 1);
    place = 1'b0;
    step(1);
    b_x = 10'd0; b_y = 10'd0;
    place = 1'b1;
    step(1);
    check("corner_tx", {bomb_tx, bomb_ty}, 0);
    wait_blast(cyc);
    for (int i = 0; i < 12; i++) begin
      v_x = 10'(sx[i] * 32 + 5);
      v_y = 10'(sy[i] * 32 + 5);
      #1;
      check($sformatf("cross_%0d_%0d", sx[i], sy[i]), explosion_on, se[i]);
    end
    wait_idle(cyc);
    check("corner_idle", busy, 0);
    place = 1'b0;
    step(1);
    bs0 = bs_cnt;
    b_x = 10'd100; b_y = 10'd100;
    place = 1'b1;
    step(1);
    step(4);
    game_over = 1'b1;
    step(1);
    check("game_over_abort", busy, 0);
    place = 1'b0;
    step(1);
    place = 1'b1;
    step(2);
    check("game_over_blocks", busy, 0);
    step(12);
    check("game_over_no_blast", bs_cnt - bs0, 0);
    game_over = 1'b0;
    step(2);
    check("no_edge_after_go", busy, 0);
    place = 1'b0;
    step(1);
    place = 1'b1;
    step(1);
    v_x = 10'd100; v_y = 10'd100;
    wait_blast(cyc);
    step(2);
    check("pre_reset_expl", explosion_on, 1);
    @(posedge sys_clk);
    #3;
    Reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_expl", explosion_on, 0);
    check("async_tx", {bomb_tx, bomb_ty}, 0);
    check("async_pulses", {blast_start, player_hit, bomb_on}, 0);
    step(2);
    Reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy) busy_seen++;
    end
    check("held_after_reset", busy_seen, 0);
    place = 1'b0;
    step(1);
    place = 1'b1;
    step(1);
    check("rearm_after_reset", busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
